// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use bubbles, multi-cycle branch flushes,
// memory-busy freezes and a sticky watchdog fault. Outputs are combinational from state + inputs.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W   = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_we,
  output logic                  ctrl_en,
  output logic [7:0]            stall_cnt,
  output logic                  mem_fault
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, FAULT} state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);

  state_e     state_q, state_d, eff_state;
  logic [2:0] flush_q, flush_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] stall_q, stall_d;
  logic       lu;

  assign lu = ex_mem_read & ((id_uses_rs & (ex_rd == id_rs)) |
                             (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    flush_d    = flush_q;
    wait_d     = wait_q;
    eff_state  = state_q;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    ctrl_en    = 1'b1;
    ifid_flush = 1'b0;

    // Leaving MEM_WAIT: this cycle already behaves as the state we return to.
    if (state_q == MEM_WAIT && !mem_busy) begin
      wait_d    = '0;
      eff_state = (flush_q != 3'd0) ? FLUSH : RUN;
      state_d   = eff_state;
    end

    if (eff_state == FAULT) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      ctrl_en = 1'b0;
    end else if (mem_busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      if (wait_q == WAIT_MAX) begin
        state_d = FAULT;
      end else begin
        wait_d  = wait_q + 8'd1;
        state_d = MEM_WAIT;
      end
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      ctrl_en    = 1'b0;
      flush_d    = FLUSH_LOAD;
      state_d    = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
    end else if (eff_state == FLUSH) begin
      ifid_flush = 1'b1;
      ctrl_en    = 1'b0;
      flush_d    = flush_q - 3'd1;
      state_d    = (flush_d == 3'd0) ? RUN : FLUSH;
    end else if (lu) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ctrl_en = 1'b0;
    end

    // Reset values must appear without waiting for a clock edge.
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
      ctrl_en    = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q != FAULT && (!ctrl_en || !pc_we) && stall_q != 8'hFF)
      stall_d = stall_q + 8'd1;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      flush_q <= '0;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
  assign mem_fault = (state_q == FAULT);

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed test-plan steps plus randomized traffic
// compared against a cycle-level behavioural model of the controller's rules.
module tb_hazard_stall_ctrl;

  localparam int RW = 2;
  localparam int FC = 3;
  localparam int MW = 15;

  logic          clk, rst;
  logic [RW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, mem_busy;
  logic          pc_we, ifid_we, ifid_flush, idex_we, ctrl_en, mem_fault;
  logic [7:0]    stall_cnt;

  hazard_stall_ctrl #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .ctrl_en(ctrl_en), .stall_cnt(stall_cnt), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: remaining flush cycles, consecutive busy cycles, fault flag, stall count.
  int m_flush_left, m_busy_run, m_scnt;
  bit m_fault;
  bit e_pc, e_ifid, e_idex, e_ctrl, e_flush;
  string cur_tag;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_busy_run   = 0;
    m_scnt       = 0;
    m_fault      = 1'b0;
  endtask

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                        input bit mr, input int rd, input bit br, input bit busy);
    id_rs = RW'(rs); id_rt = RW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mr; ex_rd = RW'(rd); branch_taken = br; mem_busy = busy;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".pc_we"}, {7'd0, pc_we}, 8'd0);
    chk({tag, ".ifid_we"}, {7'd0, ifid_we}, 8'd0);
    chk({tag, ".idex_we"}, {7'd0, idex_we}, 8'd0);
    chk({tag, ".ctrl_en"}, {7'd0, ctrl_en}, 8'd0);
    chk({tag, ".ifid_flush"}, {7'd0, ifid_flush}, 8'd1);
    chk({tag, ".stall_cnt"}, stall_cnt, 8'd0);
    chk({tag, ".mem_fault"}, {7'd0, mem_fault}, 8'd0);
  endtask

  // Called at a falling edge with inputs applied: check this cycle, advance model, move to next falling edge.
  task automatic step();
    bit lu, busy;
    #2;
    lu = ex_mem_read && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    busy = mem_busy;
    if (m_fault)                 {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b00000;
    else if (busy)               {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b00010;
    else if (branch_taken)       {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b11101;
    else if (m_flush_left > 0)   {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b11101;
    else if (lu)                 {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b00100;
    else                         {e_pc, e_ifid, e_idex, e_ctrl, e_flush} = 5'b11110;

    chk({cur_tag, ".pc_we"}, {7'd0, pc_we}, {7'd0, e_pc});
    chk({cur_tag, ".ifid_we"}, {7'd0, ifid_we}, {7'd0, e_ifid});
    chk({cur_tag, ".idex_we"}, {7'd0, idex_we}, {7'd0, e_idex});
    chk({cur_tag, ".ctrl_en"}, {7'd0, ctrl_en}, {7'd0, e_ctrl});
    chk({cur_tag, ".ifid_flush"}, {7'd0, ifid_flush}, {7'd0, e_flush});
    chk({cur_tag, ".stall_cnt"}, stall_cnt, 8'(m_scnt));
    chk({cur_tag, ".mem_fault"}, {7'd0, mem_fault}, {7'd0, m_fault});

    if (!m_fault && (!e_ctrl || !e_pc) && m_scnt < 255) m_scnt++;
    if (!m_fault) begin
      if (busy) begin
        m_busy_run++;
        if (m_busy_run > MW) m_fault = 1'b1;
      end else begin
        m_busy_run = 0;
        if (branch_taken)          m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int burst;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset, then idle inputs.
    do_reset("rst_hold");
    cur_tag = "idle";
    step();
    step();

    // Load-use on rs, then cleared, then same with rs unused.
    cur_tag = "lu_rs";
    set_in(2, 0, 1, 0, 1, 2, 0, 0);
    step();
    cur_tag = "lu_clear";
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("lu_stall_cnt", stall_cnt, 8'd1);
    cur_tag = "lu_unused";
    set_in(2, 0, 0, 0, 1, 2, 0, 0);
    step();
    chk("lu_unused_cnt", stall_cnt, 8'd1);
    cur_tag = "lu_rt";
    set_in(0, 3, 0, 1, 1, 3, 0, 0);
    step();

    // One-cycle branch: three flush cycles, then RUN.
    do_reset("rst_br");
    cur_tag = "branch";
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    cur_tag = "flush";
    set_in(1, 1, 1, 1, 1, 1, 0, 0);
    step();
    step();
    cur_tag = "after_flush";
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("flush_stall_cnt", stall_cnt, 8'd3);

    // Second branch in flush cycle 2 restarts the three-cycle flush.
    cur_tag = "br2_a";
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    cur_tag = "br2_b";
    step();
    cur_tag = "br2_flush";
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    cur_tag = "br2_run";
    step();
    chk("br2_stall_cnt", stall_cnt, 8'd7);

    // Busy for 4 cycles with branch pending; flush begins on cycle 5.
    do_reset("rst_busy");
    cur_tag = "busy_br";
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) step();
    cur_tag = "busy_br_go";
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("busy_br_flushq", {7'd0, ifid_flush}, 8'd1);
    cur_tag = "busy_br_flush";
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Busy inside a flush holds the remaining flush count.
    cur_tag = "flush_busy";
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Watchdog: 15 busy cycles is tolerated, 16 latches the fault.
    do_reset("rst_wd");
    cur_tag = "wd15";
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (15) step();
    chk("wd15_fault", {7'd0, mem_fault}, 8'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    cur_tag = "wd16";
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (16) step();
    chk("wd16_fault", {7'd0, mem_fault}, 8'd1);
    cur_tag = "fault_sticky";
    set_in(2, 0, 1, 0, 1, 2, 1, 0);
    repeat (3) step();
    chk("fault_sticky", {7'd0, mem_fault}, 8'd1);
    chk("fault_stall_cnt", stall_cnt, 8'd31);
    do_reset("rst_fault");
    chk("fault_cleared", {7'd0, mem_fault}, 8'd0);

    // Saturation over 300 load-use cycles, then asynchronous reset mid-stall.
    cur_tag = "sat";
    set_in(1, 2, 1, 1, 1, 1, 0, 0);
    repeat (300) step();
    chk("sat_cnt", stall_cnt, 8'd255);
    #3;
    chk("mid_stall_pc_we", {7'd0, pc_we}, 8'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with occasional busy bursts and resets.
    cur_tag = "rand";
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 18);
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0), (burst > 0));
      if (burst > 0) burst--;
      if (m_fault && $urandom_range(0, 9) == 0) begin
        burst = 0;
        do_reset("rand_rst");
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 8-bit pipelined processor; sits in the ID stage.
- Directly drives the enable of the 2:1 control-signal muxes feeding ID/EX. ctrl_en=0 forces those muxes to output 0, which inserts a bubble (NOP controls).
- Also generates PC / IF-ID / ID-EX write enables and the IF/ID flush.
- Handles:
  - load-use stalls
  - taken-branch flushes (multi-cycle)
  - memory-busy freezes, with a watchdog that latches a fault.

Parameters:
- REG_ADDR_W, 2, width of register-file address fields.
- FLUSH_CYCLES, 1, number of IF/ID flush cycles per taken branch (1..7).
- MAX_WAIT, 15, maximum consecutive mem_busy cycles before fault (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  REG_ADDR_W  source reg A of instruction in ID.
- id_rt  in  REG_ADDR_W  source reg B of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination reg of EX instruction.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- mem_busy  in  1  data/instruction memory not ready.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP at next edge.
- idex_we  out  1  ID/EX register write enable.
- ctrl_en  out  1  enable of control muxes; 0 = bubble.
- stall_cnt  out  8  saturating count of stall/bubble cycles.
- mem_fault  out  1  sticky watchdog fault.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While rst is high:
  - pc_we=0, ifid_we=0, idex_we=0, ctrl_en=0, ifid_flush=1.
  - stall_cnt=0, mem_fault=0, state=RUN, flush and wait counters=0.
- Outputs are combinational from state plus current inputs (zero latency); state and counters are registered.
- Load-use hazard (lu) = ex_mem_read & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- States and priority, evaluated each cycle:
  - FAULT (entered from MEM_WAIT):
    - all write enables 0, ctrl_en=0, ifid_flush=0, mem_fault=1.
    - Exit only by reset.
  - mem_busy=1 (state RUN, FLUSH or MEM_WAIT):
    - pc_we=ifid_we=idex_we=0, ctrl_en=1 (everything frozen, no bubble), ifid_flush=0.
    - Go to or stay in MEM_WAIT; wait counter increments.
    - When the counter would exceed MAX_WAIT, i.e. on the (MAX_WAIT+1)th consecutive busy cycle, go to FAULT at that edge.
    - A pending flush counter is held (not decremented).
  - MEM_WAIT with mem_busy=0:
    - wait counter clears.
    - Return to FLUSH if flush counter>0, else RUN.
    - Outputs this cycle follow the destination state's rules.
  - branch_taken=1 (not busy):
    - ifid_flush=1, ctrl_en=0 (bubble for the ID instruction), pc_we=1, ifid_we=1, idex_we=1.
    - Flush counter loads FLUSH_CYCLES-1.
    - Go to FLUSH if that value >0, else RUN.
    - A branch arriving in FLUSH restarts the counter.
    - lu is ignored.
  - FLUSH with no branch:
    - ifid_flush=1, ctrl_en=0, all write enables 1.
    - Counter decrements; go to RUN when it reaches 0.
    - lu is ignored (the ID instruction is being discarded).
  - RUN with lu=1:
    - pc_we=0, ifid_we=0, idex_we=1, ctrl_en=0 (bubble into EX), ifid_flush=0.
    - Single cycle; no state change (the next EX holds the bubble, so lu clears).
  - RUN otherwise: pc_we=ifid_we=idex_we=ctrl_en=1, ifid_flush=0.
- stall_cnt:
  - increments by 1 on each clock edge where ctrl_en=0 or pc_we=0, outside reset and FAULT.
  - saturates at 255; never wraps.
- mem_busy and branch_taken together: freeze wins. EX is frozen, so branch_taken persists and is serviced in the first non-busy cycle.

Test Plan:
- Reset then idle inputs:
  - during rst: all we=0, ctrl_en=0, ifid_flush=1.
  - after release: all we=1, ctrl_en=1, stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rd=2, id_rs=2, id_uses_rs=1 for one cycle:
  - that cycle: pc_we=0, ifid_we=0, idex_we=1, ctrl_en=0.
  - next cycle, inputs cleared: all 1.
  - stall_cnt=1.
  - Repeat with id_uses_rs=0: no stall.
- FLUSH_CYCLES=3, one-cycle branch_taken: ifid_flush=1 and ctrl_en=0 for exactly 3 cycles, then RUN; stall_cnt=3. Second branch in flush cycle 2: flush extends to 3 cycles from that point.
- mem_busy for 4 cycles with branch_taken=1 throughout:
  - 4 cycles with all we=0, ctrl_en=1, ifid_flush=0.
  - then the flush sequence starts on cycle 5.
- MAX_WAIT=15, mem_busy held 16 cycles: mem_fault=1 after the 16th edge and stays set after mem_busy drops; only rst clears it.
- 300 consecutive load-use cycles: stall_cnt saturates at 255. Assert rst mid-stall: outputs go to reset values immediately, without a clock edge.
